mem_stream_stat: RTL and testbench

- Sits directly downstream of the simple BRAM controller and consumes its read-back stream (o_valid / o_mem_data, terminated by o_done).
- Per burst, accumulates sample count, sum, minimum and maximum of the unsigned words read from BRAM.
- Presents the results as one registered record, held until acknowledged by a valid/ready handshake to the consumer.

---
 rtl/mem_stream_stat.sv | 105 ++++++++++
 tb/tb_mem_stream_stat.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_stat.sv
// Burst statistics collector: count, sum, min and max of a read-back stream.
// Ports: clk/reset_n, i_valid/i_data/i_done stream in, record out via
// o_res_valid/i_res_ready, o_count/o_sum/o_min/o_max, o_busy, o_overrun.
module mem_stream_stat #(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 8,
  parameter int SWIDTH = DWIDTH + CWIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_done,
  output logic              o_busy,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [CWIDTH-1:0] o_count,
  output logic [SWIDTH-1:0] o_sum,
  output logic [DWIDTH-1:0] o_min,
  output logic [DWIDTH-1:0] o_max,
  output logic              o_overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_t;

  localparam logic [CWIDTH-1:0] CMAX = '1;

  state_t            state_q, state_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic [SWIDTH-1:0] sum_q, sum_d;
  logic [DWIDTH-1:0] min_q, min_d;
  logic [DWIDTH-1:0] max_q, max_d;
  logic              ovr_q, ovr_d;
  logic              take;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    ovr_d   = ovr_q;
    take    = 1'b0;
    unique case (state_q)
      // Idle accumulators hold their initial values, so the
      // first sample folds in exactly like any later one.
      S_IDLE, S_ACC: begin
        if (i_valid) begin
          if (count_q == CMAX) ovr_d = 1'b1;
          else                 take  = 1'b1;
        end
        if (i_done)       state_d = S_HOLD;
        else if (i_valid) state_d = S_ACC;
      end
      S_HOLD: begin
        if (i_valid) ovr_d = 1'b1;
        if (i_res_ready) begin
          state_d = S_IDLE;
          count_d = '0;
          sum_d   = '0;
          min_d   = '1;
          max_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      count_d = count_q + 1'b1;
      sum_d   = sum_q + SWIDTH'(i_data);
      if (i_data < min_q) min_d = i_data;
      if (i_data > max_q) max_d = i_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      sum_q   <= '0;
      min_q   <= '1;
      max_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_busy      = (state_q == S_ACC);
  assign o_res_valid = (state_q == S_HOLD);
  assign o_count     = count_q;
  assign o_sum       = sum_q;
  assign o_min       = min_q;
  assign o_max       = max_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_mem_stream_stat.sv
// Bench for mem_stream_stat: directed bursts plus random traffic,
// checked every cycle against a queue-based model of the burst.
module tb_mem_stream_stat;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int SW = DW + CW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_done = 1'b0;
  logic          i_res_ready = 1'b0;
  logic          o_busy, o_res_valid, o_overrun;
  logic [CW-1:0] o_count;
  logic [SW-1:0] o_sum;
  logic [DW-1:0] o_min, o_max;

  int checks = 0;
  int failures = 0;

  mem_stream_stat #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_valid(i_valid), .i_data(i_data), .i_done(i_done),
    .o_busy(o_busy), .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready),
    .o_count(o_count), .o_sum(o_sum),
    .o_min(o_min), .o_max(o_max), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 collecting, 2 holding a record.
  int      m_mode = 0;
  int      m_q[$];
  bit      m_ovr = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0;
      m_q.delete();
      m_ovr = 1'b0;
    end else if (m_mode == 2) begin
      if (i_valid) m_ovr = 1'b1;
      if (i_res_ready) begin
        m_mode = 0;
        m_q.delete();
      end
    end else begin
      if (i_valid) begin
        if (m_q.size() == (1 << CW) - 1) m_ovr = 1'b1;
        else m_q.push_back(int'(i_data));
      end
      if (i_done) m_mode = 2;
      else if (i_valid) m_mode = 1;
    end
  end

  task automatic check(input string nm, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    longint s;
    int mn, mx;
    s = 0; mn = 'hFFFF; mx = 0;
    foreach (m_q[i]) begin
      s += m_q[i];
      if (m_q[i] < mn) mn = m_q[i];
      if (m_q[i] > mx) mx = m_q[i];
    end
    check("busy", o_busy, m_mode == 1);
    check("res_valid", o_res_valid, m_mode == 2);
    check("count", o_count, m_q.size());
    check("sum", o_sum, s);
    check("min", o_min, mn);
    check("max", o_max, mx);
    check("overrun", o_overrun, m_ovr);
  end

  task automatic cyc(input bit v, input int d, input bit dn,
                     input bit rdy);
    @(negedge clk);
    i_valid = v;
    i_data = DW'(d);
    i_done = dn;
    i_res_ready = rdy;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0);
  endtask

  task automatic pin(input string tag, input int c, input longint s,
                     input int mn, input int mx, input bit ov);
    check({tag, ".valid"}, o_res_valid, 1);
    check({tag, ".count"}, o_count, c);
    check({tag, ".sum"}, o_sum, s);
    check({tag, ".min"}, o_min, mn);
    check({tag, ".max"}, o_max, mx);
    check({tag, ".ovr"}, o_overrun, ov);
  endtask

  task automatic release_rec();
    cyc(0, 0, 0, 1);
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst.busy", o_busy, 0);
    check("rst.count", o_count, 0);
    check("rst.min", o_min, 'hFFFF);
    check("rst.ovr", o_overrun, 0);
    repeat (2) idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) idle();
    reset_n = 1'b1;
    idle();

    // Ramp
    for (int i = 0; i < 100; i++) cyc(1, i, 0, 0);
    cyc(0, 0, 1, 0);
    idle();
    pin("ramp", 100, 4950, 0, 99, 0);
    release_rec();

    // Gapped, last sample coincident with done
    cyc(1, 500, 0, 0); idle(); idle();
    cyc(1, 3, 0, 0); idle(); idle();
    cyc(1, 65535, 0, 0); idle(); idle();
    cyc(1, 7, 1, 0);
    idle();
    pin("gap", 4, 66045, 3, 65535, 0);
    release_rec();

    // Empty burst
    cyc(0, 0, 1, 0);
    idle();
    pin("empty", 0, 0, 'hFFFF, 0, 0);
    release_rec();

    // Backpressure with dropped samples
    cyc(1, 10, 0, 0);
    cyc(1, 20, 1, 0);
    for (int i = 0; i < 20; i++) cyc(i % 3 == 0, 9, 0, 0);
    idle();
    pin("bp", 2, 30, 10, 20, 1);
    release_rec();
    check("bp.clr", o_count, 0);
    cyc(1, 42, 1, 0);
    idle();
    pin("bp2", 1, 42, 42, 42, 1);
    release_rec();

    // Saturation
    do_reset();
    for (int i = 0; i < 256; i++) cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 0);
    idle();
    pin("sat", 255, 255, 1, 1, 1);
    release_rec();

    // Reset mid-burst, asserted between edges
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 77, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 5, i == 2, 0);
    idle();
    pin("rst3", 3, 15, 5, 5, 0);
    release_rec();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                      : int'($urandom_range(0, 300));
      cyc($urandom_range(0, 2) != 0, d, $urandom_range(0, 40) == 0,
          $urandom_range(0, 3) == 0);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
